// File: rtl/seg_scan_arbiter.sv
// Shares a 4-digit 7-segment display between requesters A and B, switching owner only at scan-frame boundaries.
// Optional anti-ghosting blanking at the start of each digit slot: define SCAN_BLANK_EN.
module seg_scan_arbiter #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk_raw,
  input  logic        rst_raw,
  input  logic        req_a,
  input  logic [27:0] frame_a,
  input  logic        req_b,
  input  logic [27:0] frame_b,
  output logic [6:0]  seg,
  output logic [3:0]  numsl,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        frame_strobe,
  output logic [1:0]  dig_idx
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TERM_CNT = CW'(SCAN_DIV - 1);

  if (SCAN_DIV < 2 || BLANK_CYC >= SCAN_DIV) begin : g_badParams
    $error("seg_scan_arbiter: need SCAN_DIV >= 2 and BLANK_CYC < SCAN_DIV");
  end

  typedef enum logic [1:0] {IDLE, SOLO_A, SOLO_B, SPLIT} state_t;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_dig;
  state_t        r_state;
  logic [27:0]   r_shadowA;
  logic [27:0]   r_shadowB;
  logic [6:0]    r_seg;
  logic [3:0]    r_numsl;
  logic          r_gntA;
  logic          r_gntB;
  logic          r_strobe;

  logic          w_terminal;
  logic          w_boundary;
  logic [CW-1:0] w_cntNext;
  logic [1:0]    w_digNext;
  state_t        w_stateNext;
  logic [27:0]   w_shadowANext;
  logic [27:0]   w_shadowBNext;
  logic [27:0]   w_srcFrame;
  logic [6:0]    w_digit;
  logic          w_blank;
  logic          w_lit;

  assign w_terminal    = (r_cnt == TERM_CNT);
  assign w_boundary    = w_terminal && (r_dig == 2'd3);
  assign w_cntNext     = w_terminal ? '0 : r_cnt + 1'b1;
  assign w_digNext     = w_terminal ? r_dig + 2'd1 : r_dig;
  assign w_shadowANext = w_boundary ? frame_a : r_shadowA;
  assign w_shadowBNext = w_boundary ? frame_b : r_shadowB;

  // Outputs are built from the next-cycle counter/state so seg, numsl and dig_idx land on the same edge.
  always_comb begin
    w_stateNext = r_state;
    if (w_boundary) begin
      case ({req_a, req_b})
        2'b10:   w_stateNext = SOLO_A;
        2'b01:   w_stateNext = SOLO_B;
        2'b11:   w_stateNext = SPLIT;
        default: w_stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    w_srcFrame = '0;
    case (w_stateNext)
      SOLO_A:  w_srcFrame = w_shadowANext;
      SOLO_B:  w_srcFrame = w_shadowBNext;
      SPLIT:   w_srcFrame = w_digNext[1] ? w_shadowANext : w_shadowBNext;
      default: w_srcFrame = '0;
    endcase
  end

  always_comb begin
    w_digit = '0;
    case (w_digNext)
      2'd0:    w_digit = w_srcFrame[6:0];
      2'd1:    w_digit = w_srcFrame[13:7];
      2'd2:    w_digit = w_srcFrame[20:14];
      default: w_digit = w_srcFrame[27:21];
    endcase
  end

`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);
  assign w_blank = (w_cntNext < BLANK_LIM);
`else
  assign w_blank = 1'b0;
`endif

  assign w_lit = (w_stateNext != IDLE) && !w_blank;

  always_ff @(posedge clk_raw or posedge rst_raw) begin
    if (rst_raw) begin
      r_cnt     <= TERM_CNT;
      r_dig     <= 2'd3;
      r_state   <= IDLE;
      r_shadowA <= '0;
      r_shadowB <= '0;
      r_seg     <= '0;
      r_numsl   <= 4'b1111;
      r_gntA    <= 1'b0;
      r_gntB    <= 1'b0;
      r_strobe  <= 1'b0;
    end else begin
      r_cnt     <= w_cntNext;
      r_dig     <= w_digNext;
      r_state   <= w_stateNext;
      r_shadowA <= w_shadowANext;
      r_shadowB <= w_shadowBNext;
      r_seg     <= w_lit ? w_digit : 7'h00;
      r_numsl   <= w_lit ? ~(4'b0001 << w_digNext) : 4'b1111;
      r_gntA    <= (w_stateNext == SOLO_A) || (w_stateNext == SPLIT);
      r_gntB    <= (w_stateNext == SOLO_B) || (w_stateNext == SPLIT);
      r_strobe  <= w_boundary;
    end
  end

  assign seg          = r_seg;
  assign numsl        = r_numsl;
  assign gnt_a        = r_gntA;
  assign gnt_b        = r_gntB;
  assign frame_strobe = r_strobe;
  assign dig_idx      = r_dig;

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Randomized self-checking bench for seg_scan_arbiter; the expected display is derived from the edge count since reset.
module tb_seg_scan_arbiter;
  localparam int D  = 4;
  localparam int BL = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        reqA = 1'b0;
  logic        reqB = 1'b0;
  logic [27:0] frA = '0;
  logic [27:0] frB = '0;
  logic [6:0]  seg;
  logic [3:0]  numsl;
  logic        gntA;
  logic        gntB;
  logic        strobe;
  logic [1:0]  digIdx;
  logic [15:0] obs;

  int compared   = 0;
  int mismatched = 0;

  int          mK = 0;
  logic        mReqA = 1'b0;
  logic        mReqB = 1'b0;
  logic [27:0] mShA = '0;
  logic [27:0] mShB = '0;

  always #5 clk = ~clk;

  seg_scan_arbiter #(.SCAN_DIV(D), .BLANK_CYC(BL)) dut (
    .clk_raw(clk), .rst_raw(rst), .req_a(reqA), .frame_a(frA),
    .req_b(reqB), .frame_b(frB), .seg(seg), .numsl(numsl),
    .gnt_a(gntA), .gnt_b(gntB), .frame_strobe(strobe), .dig_idx(digIdx)
  );

  assign obs = {seg, numsl, gntA, gntB, strobe, digIdx};

  // Reference: edge k after reset sits at position k-1 of a repeating 4*D-cycle frame; owner and frames latch at position 0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mK = 0; mReqA = 1'b0; mReqB = 1'b0; mShA = '0; mShB = '0;
    end else begin
      mK = mK + 1;
      if ((mK - 1) % (4 * D) == 0) begin
        mReqA = reqA; mReqB = reqB; mShA = frA; mShB = frB;
      end
    end
  end

  function automatic int slotNow();
    return (mK == 0) ? 3 : ((mK - 1) / D) % 4;
  endfunction

  function automatic int cntNow();
    return (mK == 0) ? D - 1 : (mK - 1) % D;
  endfunction

  function automatic logic [15:0] expVec();
    logic [27:0] f;
    logic [6:0]  s;
    logic [3:0]  n;
    logic        lit;
    logic        stb;
    int          p, d, c;
    if (mK == 0) return {7'h00, 4'hF, 1'b0, 1'b0, 1'b0, 2'd3};
    p = mK - 1; d = (p / D) % 4; c = p % D;
    stb = (p % (4 * D) == 0);
    lit = mReqA | mReqB;
`ifdef SCAN_BLANK_EN
    if (c < BL) lit = 1'b0;
`endif
    if (mReqA && mReqB) f = (d >= 2) ? mShA : mShB;
    else if (mReqA)     f = mShA;
    else                f = mShB;
    s = lit ? 7'(f >> (7 * d)) : 7'h00;
    n = lit ? ~(4'(1) << d) : 4'hF;
    return {s, n, mReqA, mReqB, stb, 2'(d)};
  endfunction

  task automatic test_reset();
    logic [15:0] e;
    #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    e = expVec(); compared++;
    if (obs !== e || obs !== {7'h00, 4'hF, 3'b000, 2'd3}) begin
      mismatched++; $display("[TB] FAIL reset_state got=%h want=%h", obs, e);
    end
    reqA = 1'b1; reqB = 1'b1; frA = 28'($urandom); frB = 28'($urandom);
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (strobe !== 1'b1 || obs !== expVec()) begin
      mismatched++; $display("[TB] FAIL first_strobe got=%h want=%h", obs, expVec());
    end
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      e = expVec(); compared++;
      if (obs !== e) begin mismatched++; $display("[TB] FAIL reset_run got=%h want=%h", obs, e); end
    end
    #2 rst = 1'b1;
    #1;
    compared++;
    if (seg !== 7'h00 || numsl !== 4'hF || gntA !== 1'b0 || gntB !== 1'b0 || strobe !== 1'b0) begin
      mismatched++; $display("[TB] FAIL async_clear got=%h want=%h", obs, {7'h00, 4'hF, 3'b000, 2'd3});
    end
    @(negedge clk);
    rst = 1'b0; reqA = 1'b0; reqB = 1'b0;
  endtask

  task automatic test_solo_a();
    logic [15:0] e;
    reqA = 1'b1; reqB = 1'b0; frA = 28'h0000006; frB = 28'($urandom);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = expVec(); compared++;
      if (obs !== e) begin mismatched++; $display("[TB] FAIL solo_a got=%h want=%h", obs, e); end
      if (mReqA && !mReqB && cntNow() == D - 1) begin
        compared++;
        if (slotNow() == 0 && (numsl !== 4'b1110 || seg !== 7'h06 || gntA !== 1'b1 || gntB !== 1'b0)) begin
          mismatched++; $display("[TB] FAIL solo_a_slot0 got=%h want numsl=e seg=06", obs);
        end else if (slotNow() != 0 && seg !== 7'h00) begin
          mismatched++; $display("[TB] FAIL solo_a_blank_digit got=%h want seg=00", obs);
        end
      end
    end
  endtask

  task automatic test_split();
    logic [15:0] e;
    reqA = 1'b1; reqB = 1'b1;
    frA = {7'h3F, 21'($urandom)}; frB = {21'($urandom), 7'h5B};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = expVec(); compared++;
      if (obs !== e) begin mismatched++; $display("[TB] FAIL split got=%h want=%h", obs, e); end
      if (mReqA && mReqB && mK > 16 && cntNow() == D - 1) begin
        if (slotNow() == 3) begin
          compared++;
          if (numsl !== 4'b0111 || seg !== 7'h3F) begin
            mismatched++; $display("[TB] FAIL split_slot3 got=%h want numsl=7 seg=3f", obs);
          end
        end else if (slotNow() == 0) begin
          compared++;
          if (numsl !== 4'b1110 || seg !== 7'h5B) begin
            mismatched++; $display("[TB] FAIL split_slot0 got=%h want numsl=e seg=5b", obs);
          end
        end
      end
    end
  endtask

  task automatic test_frame_hold();
    logic [15:0] e;
    logic [27:0] oldA;
    bit          changed = 0;
    reqA = 1'b1; reqB = 1'b0; oldA = 28'($urandom) | 28'h8000000; frA = oldA;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      e = expVec(); compared++;
      if (obs !== e) begin mismatched++; $display("[TB] FAIL frame_hold got=%h want=%h", obs, e); end
      if (changed && mShA == oldA && slotNow() == 3 && cntNow() == D - 1) begin
        compared++;
        if (seg !== oldA[27:21]) begin
          mismatched++; $display("[TB] FAIL frame_hold_old got=%h want seg=%h", seg, oldA[27:21]);
        end
      end
      if (!changed && mReqA && !mReqB && mShA == oldA && slotNow() == 1) begin
        frA = ~oldA; changed = 1;
      end
    end
  endtask

  task automatic test_req_drop();
    logic [15:0] e;
    bit          dropped = 0;
    reqA = 1'b1; reqB = 1'b1; frA = 28'($urandom); frB = 28'($urandom);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      e = expVec(); compared++;
      if (obs !== e) begin mismatched++; $display("[TB] FAIL req_drop got=%h want=%h", obs, e); end
      if (dropped && mReqA && mReqB) begin
        compared++;
        if (gntA !== 1'b1) begin mismatched++; $display("[TB] FAIL split_held got=%b want=1", gntA); end
      end
      if (!dropped && mReqA && mReqB && slotNow() == 2) begin
        reqA = 1'b0; dropped = 1;
      end
    end
    reqB = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      e = expVec(); compared++;
      if (obs !== e) begin mismatched++; $display("[TB] FAIL drop_both got=%h want=%h", obs, e); end
      if (!mReqA && !mReqB) begin
        compared++;
        if (numsl !== 4'hF || seg !== 7'h00) begin
          mismatched++; $display("[TB] FAIL idle_dark got=%h want numsl=f seg=00", obs);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] e;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      e = expVec(); compared++;
      if (obs !== e) begin mismatched++; $display("[TB] FAIL random got=%h want=%h", obs, e); end
      if ($urandom_range(0, 5) == 0) begin
        reqA = 1'($urandom); reqB = 1'($urandom);
      end
      if ($urandom_range(0, 3) == 0) frA = 28'($urandom);
      if ($urandom_range(0, 3) == 0) frB = 28'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_solo_a();
    test_split();
    test_frame_hold();
    test_req_drop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
